// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential restoring
//                divider (div_32x16_seq) and its iteration step (div_step).
//                Contents:
//                  div_state_e   - controller state encoding
//                  DIV_WIDTH_DEFAULT - default divisor/quotient width
//                  div_cnt_width - iteration counter width for a given WIDTH
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } div_state_e;

    // Counter must hold 0..WIDTH-1; a 1-bit floor keeps degenerate widths legal.
    function automatic int div_cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration. Shifts the
//                next dividend bit into the partial remainder and subtracts
//                the divisor when it fits.
//  Ports       : r_i       [WIDTH-1:0] partial remainder (always < divisor)
//                q_bit_i               next dividend bit shifted in
//                divisor_i [WIDTH-1:0] divisor
//                r_o       [WIDTH-1:0] updated partial remainder
//                bit_o                 resulting quotient bit
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic             q_bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] r_o,
    output logic             bit_o
);

    logic [WIDTH:0]   w_t;
    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_t    = {r_i, q_bit_i};
        w_ge   = (w_t >= {1'b0, divisor_i});
        // When T >= divisor the true difference is < divisor, so a WIDTH-bit
        // modular subtraction of the low bits yields the exact result.
        w_diff = w_t[WIDTH-1:0] - divisor_i;
        r_o    = w_ge ? w_diff : w_t[WIDTH-1:0];
        bit_o  = w_ge;
    end

endmodule
`default_nettype wire

// File: rtl/div_32x16_seq.sv
`default_nettype none
// ============================================================================
//  Module      : div_32x16_seq
//  Description : Sequential restoring divider, 2*WIDTH-bit dividend by
//                WIDTH-bit divisor, one quotient bit per clock. Divide-by-zero
//                and quotient overflow are detected up front and take a
//                two-cycle fast path.
//  Ports       : clk, rst (sync, active high)
//                start                  request, accepted in IDLE or DONE
//                dividend [2*WIDTH-1:0] captured on accepted start
//                divisor  [WIDTH-1:0]   captured on accepted start
//                sgn                    signed mode (DIV_SIGNED_EN only)
//                busy                   high while iterating
//                done                   one-cycle result-valid pulse
//                quotient, remainder    results, held until next result
//                div_zero, overflow     status flags, held with results
//  Config      : `define DIV_SIGNED_EN adds the sgn port and two's complement
//                operand support; default build is unsigned only.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_32x16_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
`ifdef DIV_SIGNED_EN
    input  logic               sgn,
`endif
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_zero,
    output logic               overflow
);

    localparam int               CNT_W    = div_cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    // rem_q:quo_q hold the raw dividend in CHECK, then the working R and Q.
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvsr_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_zero_q;
    logic             overflow_q;

    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic               w_bit;
    logic               w_accept;
    logic [2*WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0]   w_dvs_mag;
    logic [WIDTH-1:0]   w_res_quo;
    logic [WIDTH-1:0]   w_res_rem;
    logic               w_res_ovf;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .r_i       (rem_q),
        .q_bit_i   (quo_q[WIDTH-1]),
        .divisor_i (dvsr_q),
        .r_o       (rem_d),
        .bit_o     (w_bit)
    );

    assign quo_d    = {quo_q[WIDTH-2:0], w_bit};
    assign w_accept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef DIV_SIGNED_EN
    logic sgn_q;
    logic neg_quo_q;
    logic neg_rem_q;
    logic w_dvd_neg;
    logic w_dvs_neg;

    localparam logic [WIDTH-1:0] LIM_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] LIM_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    always_comb begin
        w_dvd_neg = sgn_q & rem_q[WIDTH-1];
        w_dvs_neg = sgn_q & dvsr_q[WIDTH-1];
        w_dvd_mag = w_dvd_neg ? -{rem_q, quo_q} : {rem_q, quo_q};
        w_dvs_mag = w_dvs_neg ? -dvsr_q : dvsr_q;
        // A negative result may reach -2^(W-1); a positive one only 2^(W-1)-1.
        w_res_ovf = sgn_q & (neg_quo_q ? (quo_d > LIM_NEG) : (quo_d > LIM_POS));
        w_res_quo = w_res_ovf ? ALL_ONES : (neg_quo_q ? -quo_d : quo_d);
        w_res_rem = w_res_ovf ? ALL_ONES : (neg_rem_q ? -rem_d : rem_d);
    end
`else
    always_comb begin
        w_dvd_mag = {rem_q, quo_q};
        w_dvs_mag = dvsr_q;
        w_res_ovf = 1'b0;
        w_res_quo = quo_d;
        w_res_rem = rem_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvsr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef DIV_SIGNED_EN
            sgn_q       <= 1'b0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (w_accept) begin
                state_q    <= CHECK;
                rem_q      <= dividend[2*WIDTH-1:WIDTH];
                quo_q      <= dividend[WIDTH-1:0];
                dvsr_q     <= divisor;
                div_zero_q <= 1'b0;
                overflow_q <= 1'b0;
`ifdef DIV_SIGNED_EN
                sgn_q      <= sgn;
`endif
            end else begin
                case (state_q)
                    IDLE: ;
                    CHECK: begin
                        if (w_dvs_mag == '0) begin
                            div_zero_q  <= 1'b1;
                            quotient_q  <= ALL_ONES;
                            remainder_q <= quo_q;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else if (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_dvs_mag) begin
                            overflow_q  <= 1'b1;
                            quotient_q  <= ALL_ONES;
                            remainder_q <= ALL_ONES;
                            done_q      <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            rem_q   <= w_dvd_mag[2*WIDTH-1:WIDTH];
                            quo_q   <= w_dvd_mag[WIDTH-1:0];
                            dvsr_q  <= w_dvs_mag;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= RUN;
`ifdef DIV_SIGNED_EN
                            neg_quo_q <= w_dvd_neg ^ w_dvs_neg;
                            neg_rem_q <= w_dvd_neg;
`endif
                        end
                    end
                    RUN: begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            quotient_q  <= w_res_quo;
                            remainder_q <= w_res_rem;
                            overflow_q  <= w_res_ovf;
                            state_q     <= DONE;
                        end
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule
`default_nettype wire
